// File: rtl/md_ctrl.sv
// md_ctrl: E-stage multiply/divide controller.
// Times mult/div with a down-counter, holds the result in shadow registers
// while busy, and commits it to HI/LO when the counter runs out.
// mthi/mtlo write HI/LO directly on their accept edge.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       hi_n_q, hi_n_d;
  logic [31:0]       lo_n_q, lo_n_d;
  logic              skip_q, skip_d;
  logic              done_q, done_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag, b_mag, bs_mag, quo_mag, rem_mag;
  logic [31:0] quo_s, rem_s;
  logic [31:0] bu_div, quo_u, rem_u;
  logic        accept;

  // Datapath: signed/unsigned products and quotient/remainder of the current operands.
  // Signed division works on magnitudes so the -2^31 / -1 case needs no special handling.
  always_comb begin
    prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u  = {32'b0, a} * {32'b0, b};
    a_mag   = a[31] ? (~a + 32'd1) : a;
    b_mag   = b[31] ? (~b + 32'd1) : b;
    bs_mag  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    quo_mag = a_mag / bs_mag;
    rem_mag = a_mag % bs_mag;
    quo_s   = (a[31] ^ b[31]) ? (~quo_mag + 32'd1) : quo_mag;
    rem_s   = a[31] ? (~rem_mag + 32'd1) : rem_mag;
    bu_div  = (b == 32'd0) ? 32'd1 : b;
    quo_u   = a / bu_div;
    rem_u   = a % bu_div;
  end

  // Next-state logic: accept commands in IDLE, count down in RUN, commit on the last count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    skip_d  = skip_q;
    done_d  = 1'b0;
    accept  = start & ~flush & (state_q == IDLE) & (op != 3'd0) & (op != 3'd7);

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT: begin
              {hi_n_d, lo_n_d} = prod_s;
              skip_d  = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_MULTU: begin
              {hi_n_d, lo_n_d} = prod_u;
              skip_d  = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV: begin
              hi_n_d  = rem_s;
              lo_n_d  = quo_s;
              skip_d  = (b == 32'd0);
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_DIVU: begin
              hi_n_d  = rem_u;
              lo_n_d  = quo_u;
              skip_d  = (b == 32'd0);
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          if (!skip_q) begin
            hi_d = hi_n_q;
            lo_d = lo_n_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
      skip_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
      skip_q  <= skip_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: table-driven, hand-written and random checks of md_ctrl
// against a behavioural model built on plain 64-bit arithmetic.
module tb_md_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  // Behavioural model: remaining busy cycles, pending result, committed HI/LO.
  int          m_left;
  logic [31:0] m_hi, m_lo;
  logic [31:0] m_pend_hi, m_pend_lo;
  logic        m_pend_ok;
  logic        m_done;

  md_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .flush(flush),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_busy;
    int          exp_done;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[14];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left    = 0;
    m_hi      = '0;
    m_lo      = '0;
    m_pend_hi = '0;
    m_pend_lo = '0;
    m_pend_ok = 1'b0;
    m_done    = 1'b0;
  endtask

  // One rising edge of the reference: finish an operation in flight or take a new command.
  task automatic model_edge(input logic s, input logic [2:0] o, input logic f,
                            input logic [31:0] aa, input logic [31:0] bb);
    longint      la, lb, q, r, ps;
    logic [63:0] pu;
    m_done = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_pend_ok) begin
          m_hi = m_pend_hi;
          m_lo = m_pend_lo;
        end
        m_done = 1'b1;
      end
    end else if (s && !f) begin
      la = longint'($signed(aa));
      lb = longint'($signed(bb));
      case (o)
        3'd1: begin
          ps = la * lb;
          m_pend_hi = ps[63:32];
          m_pend_lo = ps[31:0];
          m_pend_ok = 1'b1;
          m_left = MULT_N;
        end
        3'd2: begin
          pu = 64'(aa) * 64'(bb);
          m_pend_hi = pu[63:32];
          m_pend_lo = pu[31:0];
          m_pend_ok = 1'b1;
          m_left = MULT_N;
        end
        3'd3: begin
          m_pend_ok = (bb != 0);
          if (bb != 0) begin
            q = la / lb;
            r = la % lb;
            m_pend_hi = r[31:0];
            m_pend_lo = q[31:0];
          end
          m_left = DIV_N;
        end
        3'd4: begin
          m_pend_ok = (bb != 0);
          if (bb != 0) begin
            m_pend_hi = aa % bb;
            m_pend_lo = aa / bb;
          end
          m_left = DIV_N;
        end
        3'd5: m_hi = aa;
        3'd6: m_lo = aa;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge), step the model
  // on the rising edge, and compare all outputs on the following falling edge.
  task automatic applyStimulus(input logic s, input logic [2:0] o, input logic f,
                               input logic [31:0] aa, input logic [31:0] bb);
    start = s;
    op    = o;
    flush = f;
    a     = aa;
    b     = bb;
    @(posedge clk);
    model_edge(s, o, f, aa, bb);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkOutput();
    check32("cyc_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
    check32("cyc_done", {31'b0, done}, {31'b0, m_done});
    check32("cyc_hi", hi, m_hi);
    check32("cyc_lo", lo, m_lo);
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
  endtask

  // Issue one command then idle, counting busy cycles and done pulses.
  task automatic run_txn(input logic [2:0] o, input logic f, input logic [31:0] aa,
                         input logic [31:0] bb, output int busy_cnt, output int done_cnt);
    busy_cnt = 0;
    done_cnt = 0;
    applyStimulus(1'b1, o, f, aa, bb);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    for (int k = 0; k < DIV_N + 2; k++) begin
      idle_cycle();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  endtask

  initial begin
    int bc, dc;
    total = 0;
    bad   = 0;
    start = 1'b0;
    op    = 3'd0;
    flush = 1'b0;
    a     = '0;
    b     = '0;
    reset = 1'b0;
    model_reset();

    vecs[0]  = '{3'd1, 1'b0, 32'hFFFFFFFE, 32'd3,        MULT_N, 1, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{3'd2, 1'b0, 32'hFFFFFFFF, 32'd2,        MULT_N, 1, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{3'd3, 1'b0, 32'hFFFFFFF9, 32'd2,        DIV_N,  1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd4, 1'b0, 32'd7,        32'd0,        DIV_N,  1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{3'd3, 1'b0, 32'h80000000, 32'hFFFFFFFF, DIV_N,  1, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd1, 1'b1, 32'd5,        32'd5,        0,      0, 32'h00000000, 32'h80000000};
    vecs[6]  = '{3'd5, 1'b0, 32'h12345678, 32'd0,        0,      0, 32'h12345678, 32'h80000000};
    vecs[7]  = '{3'd6, 1'b0, 32'h9ABCDEF0, 32'd0,        0,      0, 32'h12345678, 32'h9ABCDEF0};
    vecs[8]  = '{3'd0, 1'b0, 32'd1,        32'd1,        0,      0, 32'h12345678, 32'h9ABCDEF0};
    vecs[9]  = '{3'd7, 1'b0, 32'd1,        32'd1,        0,      0, 32'h12345678, 32'h9ABCDEF0};
    vecs[10] = '{3'd4, 1'b0, 32'd100,      32'd7,        DIV_N,  1, 32'h00000002, 32'h0000000E};
    vecs[11] = '{3'd3, 1'b0, 32'd7,        32'hFFFFFFFE, DIV_N,  1, 32'h00000001, 32'hFFFFFFFD};
    vecs[12] = '{3'd1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, MULT_N, 1, 32'h3FFFFFFF, 32'h00000001};
    vecs[13] = '{3'd3, 1'b0, 32'd3,        32'd0,        DIV_N,  1, 32'h3FFFFFFF, 32'h00000001};

    // Reset values while reset is held low.
    #1;
    check32("rst_busy", {31'b0, busy}, 32'd0);
    check32("rst_done", {31'b0, done}, 32'd0);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_cycle();

    // Table of single commands, each run to completion.
    for (int i = 0; i < 14; i++) begin
      run_txn(vecs[i].op, vecs[i].flush, vecs[i].a, vecs[i].b, bc, dc);
      check_int($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].exp_busy);
      check_int($sformatf("vec%0d_done_pulses", i), dc, vecs[i].exp_done);
      check32($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check32($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // mthi then mtlo back to back: each lands on its own accept edge.
    applyStimulus(1'b1, 3'd5, 1'b0, 32'hCAFEF00D, 32'd0);
    check32("mthi_hi", hi, 32'hCAFEF00D);
    check32("mthi_busy", {31'b0, busy}, 32'd0);
    applyStimulus(1'b1, 3'd6, 1'b0, 32'h0BADBEEF, 32'd0);
    check32("mtlo_lo", lo, 32'h0BADBEEF);
    check32("mtlo_hi", hi, 32'hCAFEF00D);
    check32("mtlo_busy", {31'b0, busy}, 32'd0);

    // A div started during a mult run is ignored; flush during RUN does not abort.
    bc = 0;
    applyStimulus(1'b1, 3'd1, 1'b0, 32'd3, 32'd4);
    if (busy) bc++;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 3'd3, (k == 2), 32'd100, 32'd7);
      if (busy) bc++;
      check32("run_hi_old", hi, 32'hCAFEF00D);
    end
    for (int k = 0; k < 8; k++) begin
      idle_cycle();
      if (busy) bc++;
    end
    check_int("ignore_busy_cycles", bc, MULT_N);
    check32("ignore_hi", hi, 32'h00000000);
    check32("ignore_lo", lo, 32'h0000000C);

    // Reset on the third busy cycle of a div aborts it with no late commit.
    applyStimulus(1'b1, 3'd4, 1'b0, 32'd1000, 32'd3);
    idle_cycle();
    idle_cycle();
    check32("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check32("mid_rst_busy", {31'b0, busy}, 32'd0);
    check32("mid_rst_hi", hi, 32'd0);
    check32("mid_rst_lo", lo, 32'd0);
    check32("mid_rst_done", {31'b0, done}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    dc = 0;
    for (int k = 0; k < DIV_N + 4; k++) begin
      idle_cycle();
      if (done) dc++;
    end
    check_int("post_rst_done_pulses", dc, 0);
    check32("post_rst_lo", lo, 32'd0);

    // Random traffic, including starts while busy, flushes and zero divisors.
    for (int k = 0; k < 600; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
